// File: rtl/fsk2_rx_if.sv
// Sample stream in and decoded word out for the 2-FSK receiver.
// The bench drives through master and the receiver attaches as slave.
interface fsk2_rx_if;
  logic        rx_flag;
  logic [15:0] rx;
  logic [15:0] data_out;
  logic        data_valid;
  logic        frame_err;

  modport master (output rx_flag, rx, input data_out, data_valid, frame_err);
  modport slave  (input rx_flag, rx, output data_out, data_valid, frame_err);
endinterface

// File: rtl/fsk2_rx.sv
// 2-FSK receiver: counts midpoint crossings per bit and decodes 16-bit words MSB first.
// data_valid follows the last sample of a frame by one cycle; rx_flag low mid-frame aborts it.
module fsk2_rx #(
  parameter logic [15:0] BIT_LEN   = 16'd1000,
  parameter logic [7:0]  ZC_THRESH = 8'd6,
  parameter logic [15:0] MID       = 16'd32768
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  fsk2_rx_if.slave rx_if
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] sample_cnt_q, sample_cnt_d;
  logic [7:0]  zc_cnt_q, zc_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic        prev_above_q, prev_above_d;
  logic [15:0] data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;

  logic        above;
  logic [7:0]  zc_inc;
  logic [7:0]  zc_new;
  logic        bit_dec;

  assign above = (rx_if.rx >= MID);

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    zc_cnt_d     = zc_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    prev_above_d = prev_above_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    // Crossing count including the current sample, saturating at 255
    zc_inc  = (zc_cnt_q == 8'hFF) ? zc_cnt_q : zc_cnt_q + 8'd1;
    zc_new  = (above != prev_above_q) ? zc_inc : zc_cnt_q;
    bit_dec = (zc_new >= ZC_THRESH);

    case (state_q)
      ST_IDLE: begin
        if (rx_if.rx_flag) begin
          // First sample only seeds the level; it cannot close a bit since BIT_LEN >= 2
          state_d      = ST_RECV;
          prev_above_d = above;
          sample_cnt_d = 16'd1;
          zc_cnt_d     = 8'd0;
          bit_cnt_d    = 4'd0;
          shreg_d      = 16'd0;
        end
      end
      ST_RECV: begin
        if (!rx_if.rx_flag) begin
          frame_err_d  = 1'b1;
          state_d      = ST_IDLE;
          sample_cnt_d = 16'd0;
          zc_cnt_d     = 8'd0;
          bit_cnt_d    = 4'd0;
          shreg_d      = 16'd0;
        end else begin
          prev_above_d = above;
          if (sample_cnt_q == BIT_LEN - 16'd1) begin
            shreg_d      = {shreg_q[14:0], bit_dec};
            sample_cnt_d = 16'd0;
            zc_cnt_d     = 8'd0;
            if (bit_cnt_q == 4'd15) begin
              data_out_d   = {shreg_q[14:0], bit_dec};
              data_valid_d = 1'b1;
              state_d      = ST_DONE;
              bit_cnt_d    = 4'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 16'd1;
            zc_cnt_d     = zc_new;
          end
        end
      end
      ST_DONE: begin
        // Wait for a low rx_flag cycle so a lingering frame cannot retrigger
        if (!rx_if.rx_flag) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= 16'd0;
      zc_cnt_q     <= 8'd0;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= 16'd0;
      prev_above_q <= 1'b0;
      data_out_q   <= 16'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      zc_cnt_q     <= zc_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      prev_above_q <= prev_above_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_if.data_out   = data_out_q;
  assign rx_if.data_valid = data_valid_q;
  assign rx_if.frame_err  = frame_err_q;

endmodule

// File: tb/tb_fsk2_rx.sv
// Directed bench for fsk2_rx with BIT_LEN=64, ZC_THRESH=6: vector table plus corner-case sequences.
module tb_fsk2_rx;
  localparam int BL = 64;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  fsk2_rx_if bus ();

  fsk2_rx #(.BIT_LEN(16'd64), .ZC_THRESH(8'd6), .MID(16'd32768)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx_if    (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle
  int nvalid = 0, nerr = 0, noverlap = 0, valid_cyc = 0;
  logic [15:0] vals[$];
  always @(negedge sys_clk) begin
    if (bus.data_valid) begin
      nvalid++;
      valid_cyc = cyc;
      vals.push_back(bus.data_out);
    end
    if (bus.frame_err) nerr++;
    if (bus.data_valid && bus.frame_err) noverlap++;
  end

  int checks = 0, errors = 0;
  int last_samp = 0;
  int tcnt[16];
  logic cur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [15:0] v);
    @(negedge sys_clk);
    bus.rx_flag = f;
    bus.rx = v;
    if (f) last_samp = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000);
  endtask

  // tone1 -> 8 crossings per bit, tone0 -> 4
  task automatic set_tones(input logic [15:0] w);
    for (int i = 0; i < 16; i++) tcnt[i] = w[i] ? 8 : 4;
  endtask

  // Bit with t crossings: level toggles at samples 0,4,..,4(t-1) of the bit
  task automatic send_frame(input int nsamp, input logic [15:0] hi, input logic [15:0] lo);
    int b, k;
    for (int s = 0; s < nsamp; s++) begin
      b = 15 - s / BL;
      k = s % BL;
      if ((k % 4 == 0) && (k / 4 < tcnt[b])) cur = ~cur;
      drive(1'b1, cur ? hi : lo);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [15:0] hi;
    logic [15:0] lo;
    int          nsamp;
    logic [15:0] exp_out;
    int          exp_valid;
    int          exp_err;
    bit          chk_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bv, be, bq;
    vecs[0] = '{16'hFEC8, 16'hC000, 16'h4000, 1024, 16'hFEC8, 1, 0, 1'b1};
    vecs[1] = '{16'h5A3C, 16'h8000, 16'h7FFF, 1024, 16'h5A3C, 1, 0, 1'b0};
    vecs[2] = '{16'h1234, 16'hC000, 16'h4000, 500,  16'h5A3C, 0, 1, 1'b0};
    vecs[3] = '{16'h1234, 16'hC000, 16'h4000, 1023, 16'h5A3C, 0, 1, 1'b0};

    bus.rx_flag = 1'b0;
    bus.rx = 16'h0000;
    repeat (3) @(negedge sys_clk);
    check("rst_data_out", {16'h0, bus.data_out}, 32'h0);
    check("rst_data_valid", {31'h0, bus.data_valid}, 32'h0);
    check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
    sys_rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 4; i++) begin
      bv = nvalid; be = nerr;
      set_tones(vecs[i].word);
      send_frame(vecs[i].nsamp, vecs[i].hi, vecs[i].lo);
      idle(3);
      check($sformatf("v%0d_nvalid", i), nvalid - bv, vecs[i].exp_valid);
      check($sformatf("v%0d_nerr", i), nerr - be, vecs[i].exp_err);
      check($sformatf("v%0d_data_out", i), {16'h0, bus.data_out}, {16'h0, vecs[i].exp_out});
      if (vecs[i].chk_lat) check($sformatf("v%0d_latency", i), valid_cyc - last_samp, 1);
    end

    // Back-to-back frames with a single low cycle between them
    bv = nvalid; be = nerr; bq = vals.size();
    set_tones(16'h0000);
    send_frame(1024, 16'hC000, 16'h4000);
    idle(1);
    set_tones(16'hFFFF);
    send_frame(1024, 16'hC000, 16'h4000);
    idle(3);
    check("b2b_nvalid", nvalid - bv, 2);
    check("b2b_nerr", nerr - be, 0);
    if (vals.size() >= bq + 2) begin
      check("b2b_first", {16'h0, vals[bq]}, 32'h0000);
      check("b2b_second", {16'h0, vals[bq + 1]}, 32'hFFFF);
    end else begin
      check("b2b_pulses_seen", vals.size() - bq, 2);
    end

    // rx_flag held past the end, then a frame right after one low cycle
    bv = nvalid; be = nerr; bq = vals.size();
    set_tones(16'hA5A5);
    send_frame(1024, 16'hC000, 16'h4000);
    for (int i = 0; i < 200; i++) begin
      if (i % 4 == 0) cur = ~cur;
      drive(1'b1, cur ? 16'hC000 : 16'h4000);
    end
    idle(1);
    set_tones(16'h0F0F);
    send_frame(1024, 16'hC000, 16'h4000);
    idle(3);
    check("hold_nvalid", nvalid - bv, 2);
    check("hold_nerr", nerr - be, 0);
    if (vals.size() >= bq + 2) begin
      check("hold_word", {16'h0, vals[bq]}, 32'hA5A5);
      check("hold_next_word", {16'h0, vals[bq + 1]}, 32'h0F0F);
    end else begin
      check("hold_pulses_seen", vals.size() - bq, 2);
    end

    // Reset asserted during bit 7 clears outputs at once and pulses nothing
    bv = nvalid; be = nerr;
    set_tones(16'h1234);
    send_frame(7 * BL + 20, 16'hC000, 16'h4000);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    bus.rx_flag = 1'b0;
    #1;
    check("mrst_data_out", {16'h0, bus.data_out}, 32'h0);
    check("mrst_data_valid", {31'h0, bus.data_valid}, 32'h0);
    check("mrst_frame_err", {31'h0, bus.frame_err}, 32'h0);
    idle(2);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(2);
    check("mrst_no_valid", nvalid - bv, 0);
    check("mrst_no_err", nerr - be, 0);
    send_frame(1024, 16'hC000, 16'h4000);
    idle(3);
    check("mrst_next_nvalid", nvalid - bv, 1);
    check("mrst_next_word", {16'h0, bus.data_out}, 32'h1234);

    // Threshold: bits with exactly 5 crossings decode 0, exactly 6 decode 1
    bv = nvalid;
    set_tones(16'h0000);
    tcnt[10] = 5; tcnt[9] = 6; tcnt[3] = 6; tcnt[2] = 5;
    send_frame(1024, 16'hC000, 16'h4000);
    idle(3);
    check("thr_nvalid", nvalid - bv, 1);
    check("thr_word", {16'h0, bus.data_out}, 32'h0208);

    check("valid_err_overlap", noverlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
